// File: rtl/dadd_arbiter.sv
// dadd_arbiter: round-robin arbiter that shares one in-order dadd unit among
// NUM_REQ requesters and routes each result back to the requester that issued it.
//
// Ports:
//   clk, reset            - sole clock; synchronous active-high reset
//   arb_en                - grant enable (outstanding ops keep draining when low)
//   req_valid/req_ready   - per-requester handshake (req_ready is combinational)
//   req_addr/req_data     - packed per-requester address/operand, 32 bits each
//   dadd_in_en/addr/dadd_in      - registered issue to the dadd unit
//   dadd_out_en/addr/dadd_out    - result from the dadd unit (in issue order)
//   rsp_valid/rsp_addr/rsp_data  - registered one-hot routed result
//   outst_cnt             - issued-but-unanswered operation count
//   err_unexp             - one-cycle pulse on a result with nothing outstanding
module dadd_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic                   dadd_in_en,
  output logic [31:0]            dadd_in_addr,
  output logic [31:0]            dadd_in,
  input  logic                   dadd_out_en,
  input  logic [31:0]            dadd_out_addr,
  input  logic [31:0]            dadd_out,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_addr,
  output logic [31:0]            rsp_data,
  output logic [3:0]             outst_cnt,
  output logic                   err_unexp
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = 4;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   tag_mem_q [MAX_OUTST];

  logic               din_en_q, din_en_d;
  logic [31:0]        din_addr_q, din_addr_d;
  logic [31:0]        din_data_q, din_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_addr_q, rsp_addr_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [31:0]        sel_addr, sel_data;
  logic               hs;
  logic               pop;
  logic               unexp;
  logic [IDX_W-1:0]   head_tag;
  int unsigned        cand;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        sel_addr = req_addr[32*i +: 32];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // Credit check uses the registered count only, so a credit freed this cycle
  // cannot be reused until the next one.
  always_comb begin
    hs        = ~reset & arb_en & gnt_found & (cnt_q < CNT_W'(MAX_OUTST));
    req_ready = hs ? (NUM_REQ'(1) << gnt_idx) : '0;
    pop       = dadd_out_en & (cnt_q != '0);
    unexp     = dadd_out_en & (cnt_q == '0);
    head_tag  = tag_mem_q[rd_ptr_q];
  end

  // Next-state and registered-output logic.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    din_en_d    = hs;
    din_addr_d  = din_addr_q;
    din_data_d  = din_data_q;
    rsp_valid_d = '0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    err_d       = unexp;

    if (hs) begin
      din_addr_d = sel_addr;
      din_data_d = sel_data;
      rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      wr_ptr_d   = (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rsp_valid_d = NUM_REQ'(1) << head_tag;
      rsp_addr_d  = dadd_out_addr;
      rsp_data_d  = dadd_out;
      rd_ptr_d    = (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      din_en_q    <= 1'b0;
      din_addr_q  <= '0;
      din_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      din_en_q    <= din_en_d;
      din_addr_q  <= din_addr_d;
      din_data_q  <= din_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (hs) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

  assign dadd_in_en   = din_en_q;
  assign dadd_in_addr = din_addr_q;
  assign dadd_in      = din_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_addr     = rsp_addr_q;
  assign rsp_data     = rsp_data_q;
  assign outst_cnt    = cnt_q;
  assign err_unexp    = err_q;

endmodule

// File: tb/tb_dadd_arbiter.sv
// tb_dadd_arbiter: directed scenarios followed by a randomized phase, every
// cycle compared against a queue-based reference model of the arbiter.
module tb_dadd_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_OUTST = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_data;
  logic                  dadd_in_en;
  logic [31:0]           dadd_in_addr;
  logic [31:0]           dadd_in;
  logic                  dadd_out_en;
  logic [31:0]           dadd_out_addr;
  logic [31:0]           dadd_out;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_addr;
  logic [31:0]           rsp_data;
  logic [3:0]            outst_cnt;
  logic                  err_unexp;

  always #5 clk = ~clk;

  dadd_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .dadd_in_en(dadd_in_en), .dadd_in_addr(dadd_in_addr), .dadd_in(dadd_in),
    .dadd_out_en(dadd_out_en), .dadd_out_addr(dadd_out_addr), .dadd_out(dadd_out),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  // Reference model: outstanding ops as a queue in issue order.
  typedef struct {
    int          tag;
    logic [31:0] addr;
    logic [31:0] data;
    int          issue_cyc;
  } op_t;

  op_t                q[$];
  int                 m_rr;
  logic               m_din_en;
  logic [31:0]        m_din_addr, m_din;
  logic [NUM_REQ-1:0] m_rsp_valid;
  logic [31:0]        m_rsp_addr, m_rsp_data;
  logic               m_err;

  int                 cyc;
  int                 n_tests;
  int                 n_fail;
  logic [NUM_REQ-1:0] obs_ready;
  int                 gcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Stub dadd unit: mode 0 idle, 1 fixed latency, 2 random latency >= 1,
  // 3 spurious result regardless of outstanding ops.
  task automatic drive_result(input int mode, input int lat);
    dadd_out_en = 1'b0;
    if (q.size() > 0 &&
        ((mode == 1 && cyc >= q[0].issue_cyc + lat) ||
         (mode == 2 && cyc >= q[0].issue_cyc + 1 && $urandom_range(0, 1) == 1))) begin
      dadd_out_en   = 1'b1;
      dadd_out_addr = q[0].addr;
      dadd_out      = q[0].data * 2;
    end else if (mode == 3) begin
      dadd_out_en   = 1'b1;
      dadd_out_addr = $urandom;
      dadd_out      = $urandom;
    end
  endtask

  // One clock cycle: check the combinational ready, advance the model, clock,
  // then check all registered outputs.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    int g;
    op_t o;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!reset && arb_en && q.size() < MAX_OUTST) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_rr + k) % NUM_REQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (reset) begin
      q.delete();
      m_rr = 0; m_din_en = 0; m_din_addr = 0; m_din = 0;
      m_rsp_valid = '0; m_rsp_addr = 0; m_rsp_data = 0; m_err = 0;
    end else begin
      m_rsp_valid = '0;
      m_err = 1'b0;
      if (dadd_out_en) begin
        if (q.size() > 0) begin
          o = q.pop_front();
          m_rsp_valid[o.tag] = 1'b1;
          m_rsp_addr = dadd_out_addr;
          m_rsp_data = dadd_out;
        end else begin
          m_err = 1'b1;
        end
      end
      m_din_en = 1'b0;
      if (g >= 0) begin
        m_din_en   = 1'b1;
        m_din_addr = req_addr[32*g +: 32];
        m_din      = req_data[32*g +: 32];
        q.push_back('{g, req_addr[32*g +: 32], req_data[32*g +: 32], cyc + 1});
        m_rr = (g + 1) % NUM_REQ;
      end
    end

    @(posedge clk);
    cyc++;
    #1;
    chk("dadd_in_en",   32'(dadd_in_en),  32'(m_din_en));
    chk("dadd_in_addr", dadd_in_addr,     m_din_addr);
    chk("dadd_in",      dadd_in,          m_din);
    chk("rsp_valid",    32'(rsp_valid),   32'(m_rsp_valid));
    chk("rsp_addr",     rsp_addr,         m_rsp_addr);
    chk("rsp_data",     rsp_data,         m_rsp_data);
    chk("outst_cnt",    32'(outst_cnt),   32'(q.size()));
    chk("err_unexp",    32'(err_unexp),   32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '1;
    arb_en = 1'b1;
    drive_result(0, 0);
    step();
    step();
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[32*i +: 32] = $urandom;
      req_data[32*i +: 32] = $urandom;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; gcount = 0;
    m_rr = 0; m_din_en = 0; m_din_addr = 0; m_din = 0;
    m_rsp_valid = '0; m_rsp_addr = 0; m_rsp_data = 0; m_err = 0;
    reset = 1'b1; arb_en = 1'b0; req_valid = '0;
    req_addr = '0; req_data = '0;
    dadd_out_en = 1'b0; dadd_out_addr = '0; dadd_out = '0;
    @(posedge clk);
    #1;

    // Reset values, with requests pending during reset.
    do_reset();
    chk("reset_cnt", 32'(outst_cnt), 32'd0);
    chk("reset_rsp", 32'(rsp_valid), 32'd0);

    // Single requester 2: issue latency 1 and routed result.
    req_valid = 4'b0100;
    req_addr[64 +: 32] = 32'h10;
    req_data[64 +: 32] = 32'h5;
    step();
    chk("single_ready", 32'(obs_ready), 32'h4);
    chk("single_issue_en", 32'(dadd_in_en), 32'd1);
    chk("single_issue_addr", dadd_in_addr, 32'h10);
    chk("single_issue_data", dadd_in, 32'h5);
    req_valid = '0;
    step();
    chk("single_issue_drop", 32'(dadd_in_en), 32'd0);
    drive_result(1, 1);
    step();
    dadd_out_en = 1'b0;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_addr", rsp_addr, 32'h10);
    chk("single_rsp_data", rsp_data, 32'hA);

    // All requesters active, results 3 cycles after issue: strict rotation.
    do_reset();
    rand_payload();
    req_valid = 4'hF;
    for (int n = 0; n < 24; n++) begin
      drive_result(1, 3);
      step();
      if (obs_ready != '0) begin
        chk("rr_order", 32'(obs_ready), 32'(1) << (gcount % NUM_REQ));
        gcount++;
      end
    end
    req_valid = '0;
    for (int n = 0; n < 8; n++) begin
      drive_result(1, 3);
      step();
    end
    chk("rr_drained", 32'(outst_cnt), 32'd0);

    // Credits exhausted; a freed credit is not reused in the same cycle.
    do_reset();
    rand_payload();
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      drive_result(0, 0);
      step();
    end
    chk("full_cnt", 32'(outst_cnt), 32'd4);
    chk("full_ready", 32'(obs_ready), 32'd0);
    drive_result(1, 0);
    step();
    chk("free_same_cycle_ready", 32'(obs_ready), 32'd0);
    chk("free_cnt", 32'(outst_cnt), 32'd3);
    drive_result(0, 0);
    step();
    chk("free_next_ready", 32'(obs_ready), 32'h1);
    chk("refill_cnt", 32'(outst_cnt), 32'd4);
    req_valid = '0;
    for (int n = 0; n < 6; n++) begin
      drive_result(1, 0);
      step();
    end

    // Handshake and result in the same cycle keep the count.
    do_reset();
    rand_payload();
    req_valid = 4'b0011;
    drive_result(0, 0);
    step();
    step();
    chk("pre_cnt", 32'(outst_cnt), 32'd2);
    req_valid = 4'b0100;
    drive_result(1, 0);
    step();
    chk("both_ready", 32'(obs_ready), 32'h4);
    chk("both_cnt", 32'(outst_cnt), 32'd2);
    chk("both_rsp", 32'(rsp_valid), 32'h1);
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      drive_result(1, 0);
      step();
    end

    // Result with nothing outstanding.
    do_reset();
    drive_result(3, 0);
    step();
    chk("unexp_err", 32'(err_unexp), 32'd1);
    chk("unexp_rsp", 32'(rsp_valid), 32'd0);
    chk("unexp_cnt", 32'(outst_cnt), 32'd0);
    drive_result(0, 0);
    step();
    chk("unexp_pulse", 32'(err_unexp), 32'd0);

    // Reset with three ops in flight, then three late results.
    do_reset();
    rand_payload();
    req_valid = 4'b0111;
    drive_result(0, 0);
    for (int n = 0; n < 3; n++) step();
    req_valid = '0;
    chk("inflight_cnt", 32'(outst_cnt), 32'd3);
    do_reset();
    chk("midrst_cnt", 32'(outst_cnt), 32'd0);
    chk("midrst_din_en", 32'(dadd_in_en), 32'd0);
    for (int n = 0; n < 3; n++) begin
      drive_result(3, 0);
      step();
      chk("late_err", 32'(err_unexp), 32'd1);
      chk("late_rsp", 32'(rsp_valid), 32'd0);
    end
    drive_result(0, 0);

    // Randomized traffic with arb_en toggling, occasional reset and spurious results.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 149) == 0);
      arb_en    = ($urandom_range(0, 7) != 0);
      req_valid = NUM_REQ'($urandom);
      rand_payload();
      if (q.size() == 0 && $urandom_range(0, 39) == 0) drive_result(3, 0);
      else drive_result(2, 0);
      step();
    end
    reset = 1'b0;
    req_valid = '0;
    for (int n = 0; n < 40; n++) begin
      drive_result(2, 0);
      step();
    end
    drive_result(0, 0);
    step();
    chk("final_drain", 32'(outst_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dadd_arbiter.md
DADD_ARBITER -- requirements
Module: dadd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the dadd unit (2..8).
REQ-002 SHALL have parameter MAX_OUTST, default 4, max issued-but-unanswered dadd operations (1..8, power of 2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports, in this order:
- clk  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous active-high reset.
- arb_en  in  1  grant enable; low blocks new grants, in-flight ops still complete.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_addr  in  NUM_REQ*32  request address; requester i occupies bits [32i+31:32i].
- req_data  in  NUM_REQ*32  request operand, same packing.
- dadd_in_en  out  1  issue strobe to dadd unit.
- dadd_in_addr  out  32  issued address.
- dadd_in  out  32  issued operand.
- dadd_out_en  in  1  dadd result strobe.
- dadd_out_addr  in  32  result address.
- dadd_out  in  32  result data.
- rsp_valid  out  NUM_REQ  one-hot result strobe to the owning requester.
- rsp_addr  out  32  routed result address.
- rsp_data  out  32  routed result data.
- outst_cnt  out  4  current outstanding count.
- err_unexp  out  1  one-cycle pulse on a result with no outstanding op.

Function
REQ-005 SHALL treat the dadd unit as returning exactly one result per issue, in issue order, at any latency >= 1.
REQ-006 SHALL arbitrate round-robin: grant the lowest index i >= rr_ptr (mod NUM_REQ) with req_valid[i]=1.
REQ-007 SHALL assert req_ready[i] combinationally, only for the granted i, and only when arb_en=1 and outst_cnt < MAX_OUTST.
REQ-008 SHALL count a handshake when req_valid[i] & req_ready[i]; at most one handshake per cycle.
REQ-009 SHALL advance rr_ptr to (i+1) mod NUM_REQ on a handshake; rr_ptr SHALL hold otherwise.
REQ-010 SHALL register the issue: on the cycle after a handshake, dadd_in_en=1 with dadd_in_addr/dadd_in = the accepted req_addr/req_data (latency 1).
REQ-011 SHALL drive dadd_in_en=0 in cycles without a preceding handshake; dadd_in_addr/dadd_in SHALL hold their last value.
REQ-012 SHALL push the granted index into an in-order tag FIFO of depth MAX_OUTST on each handshake.
REQ-013 SHALL, on dadd_out_en=1 with FIFO non-empty, pop the head tag t and on the next cycle pulse rsp_valid[t]=1 with rsp_addr=dadd_out_addr and rsp_data=dadd_out (latency 1).
REQ-014 SHALL keep rsp_valid all zero when no result is routed; rsp_addr/rsp_data SHALL hold.
REQ-015 SHALL maintain outst_cnt: +1 on handshake, -1 on valid pop, unchanged on both in the same cycle; never exceeds MAX_OUTST.
REQ-016 SHALL NOT reuse a credit freed in the same cycle: when outst_cnt=MAX_OUTST, req_ready stays 0 even if dadd_out_en=1 that cycle.
REQ-017 SHALL, on dadd_out_en=1 with the FIFO empty, drop the result, leave outst_cnt=0, assert no rsp_valid, and pulse err_unexp=1 on the next cycle.
REQ-018 SHALL wrap the FIFO read/write pointers modulo MAX_OUTST.
REQ-019 SHALL, when arb_en falls, keep draining outstanding results per REQ-013.

Reset
REQ-020 SHALL, while reset=1 at a clk edge, set rr_ptr=0, FIFO empty, outst_cnt=0, dadd_in_en=0, dadd_in_addr=0, dadd_in=0, rsp_valid=0, rsp_addr=0, rsp_data=0, err_unexp=0.
REQ-021 SHALL force req_ready=0 while reset=1.
REQ-022 SHALL, on reset mid-operation, discard all outstanding tags; results arriving after reset are unexpected per REQ-017.

Verification
REQ-023 All 4 req_valid=1 held, results returned 3 cycles after each issue -> grants in order 0,1,2,3,0,...; each rsp_valid[i] returns the matching result.
REQ-024 Requester 2 alone issues addr 0x10 data 0x5 -> dadd_in_en=1 next cycle with 0x10/0x5; result 0x10/0xA -> rsp_valid=4'b0100, rsp_addr 0x10, rsp_data 0xA one cycle later.
REQ-025 Hold results back, issue 4 ops -> outst_cnt=4, req_ready=0; single result with req_valid high -> no same-cycle grant, grant next cycle, outst_cnt back to 4.
REQ-026 Handshake and result in the same cycle at outst_cnt=2 -> outst_cnt stays 2; FIFO order preserved across pointer wrap (>= 9 ops).
REQ-027 dadd_out_en pulse with no outstanding -> err_unexp one pulse, rsp_valid=0, outst_cnt=0.
REQ-028 Reset asserted with 3 ops outstanding -> all outputs at reset values; 3 late results -> 3 err_unexp pulses, no rsp_valid.
